// File: rtl/ctrl_pkg.sv
// Shared definitions for the datapath microsequencer.
//   - state encodings (5-bit, legacy-compatible localparams)
//   - opcode and ALU function-select constants
//   - IR field bit positions
//   - ctrl_t: one registered control vector (all controller outputs)
package ctrl_pkg;

  localparam int STATE_W = 5;

  localparam logic [4:0] ST_F0  = 5'd0;
  localparam logic [4:0] ST_F1  = 5'd1;
  localparam logic [4:0] ST_F2  = 5'd2;
  localparam logic [4:0] ST_FW  = 5'd3;
  localparam logic [4:0] ST_DEC = 5'd4;
  localparam logic [4:0] ST_A0  = 5'd5;
  localparam logic [4:0] ST_A1  = 5'd6;
  localparam logic [4:0] ST_A2  = 5'd7;
  localparam logic [4:0] ST_A3  = 5'd8;
  localparam logic [4:0] ST_A4  = 5'd9;
  localparam logic [4:0] ST_L0  = 5'd10;
  localparam logic [4:0] ST_L1  = 5'd11;
  localparam logic [4:0] ST_L2  = 5'd12;
  localparam logic [4:0] ST_LW  = 5'd13;
  localparam logic [4:0] ST_L3  = 5'd14;
  localparam logic [4:0] ST_L4  = 5'd15;
  localparam logic [4:0] ST_S0  = 5'd16;
  localparam logic [4:0] ST_S1  = 5'd17;
  localparam logic [4:0] ST_S2  = 5'd18;
  localparam logic [4:0] ST_S3  = 5'd19;
  localparam logic [4:0] ST_S4  = 5'd20;
  localparam logic [4:0] ST_S5  = 5'd21;
  localparam logic [4:0] ST_SW  = 5'd22;
  localparam logic [4:0] ST_HLT = 5'd23;
  localparam logic [4:0] ST_FLT = 5'd24;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  localparam logic [2:0] FNSEL_PASS = 3'b000;
  localparam logic [2:0] FNSEL_ADD  = 3'b100;
  localparam logic [2:0] FNSEL_SUB  = 3'b101;
  localparam logic [2:0] FNSEL_AND  = 3'b110;
  localparam logic [2:0] FNSEL_OR   = 3'b111;

  localparam int IR_OP_HI = 15;
  localparam int IR_OP_LO = 12;
  localparam int IR_RD_HI = 11;
  localparam int IR_RD_LO = 9;
  localparam int IR_RS_HI = 8;
  localparam int IR_RS_LO = 6;

  typedef struct packed {
    logic       lmar;
    logic       lt;
    logic       lpc;
    logic       lir;
    logic       lmdr;
    logic       ldx;
    logic       ldy;
    logic       tt;
    logic       tpc;
    logic       tp;
    logic       t2;
    logic       tmdr2x;
    logic       rmdri;
    logic       rmarx;
    logic       rdr;
    logic       wrr;
    logic [2:0] pa;
    logic [2:0] wpa;
    logic [2:0] fnsel;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       fault;
  } ctrl_t;

  function automatic logic [2:0] fnsel_for_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return FNSEL_ADD;
      OP_SUB:  return FNSEL_SUB;
      OP_AND:  return FNSEL_AND;
      OP_OR:   return FNSEL_OR;
      default: return FNSEL_PASS;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state timer.
//   clk, rst (sync, active-low)
//   clr     : force count to 0 (held while not in a wait state)
//   en      : count one more cycle without mem_ready
//   count   : cycles spent waiting so far in the current wait state
//   expired : this is the last allowed wait cycle (count == LIMIT-1)
module mem_wait_timer #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  always_ff @(posedge clk) begin
    if (!rst)     count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + CNT_W'(1);
  end

  // The wait cycle with count == LIMIT-1 is the LIMIT-th one.
  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/datapath_controller.sv
// Moore microsequencer for the 16-bit bus datapath.
// Inputs : clk, rst (sync, active-low), run, ir[15:0], mem_ready
// Outputs: register load strobes, bus tristate enables, MDR source selects,
//          reg-bank read/write strobes and addresses, ALU fnsel,
//          mem_rd/mem_wr requests, sticky halted/fault flags.
//
// state | meaning
// F0    | idle / PC onto bus, wait for run
// F1    | MAR <- PC, X <- 2
// F2    | PC <- PC + 2
// FW    | instruction read wait
// DEC   | decode IR
// A0-A4 | ALU op: X <- rd, Y <- rs, rd <- X op Y
// L0-L4 | load: MAR <- rs, MDR <- M[MAR], rd <- MDR
// LW    | load read wait
// S0-S5 | store: MAR <- rs, MDR <- rd
// SW    | store write wait
// HLT   | halted until reset
// FLT   | fault until reset
module datapath_controller
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        mem_ready,
  output logic        lmar,
  output logic        lt,
  output logic        lpc,
  output logic        lir,
  output logic        lmdr,
  output logic        ldx,
  output logic        ldy,
  output logic        tt,
  output logic        tpc,
  output logic        tp,
  output logic        t2,
  output logic        tmdr2x,
  output logic        rmdri,
  output logic        rmarx,
  output logic        rdr,
  output logic        wrr,
  output logic [2:0]  pa,
  output logic [2:0]  wpa,
  output logic [2:0]  fnsel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        fault
);

  logic [STATE_W-1:0] state, state_next;
  ctrl_t              ctrl_q;
  logic [3:0]         op;
  logic [2:0]         rd_f, rs_f;
  logic               in_wait, expired;
  logic [CNT_W-1:0]   wait_count;
  logic               unused_bits;

  // IR is a datapath register that stays stable until the next lir.
  assign op   = ir[IR_OP_HI:IR_OP_LO];
  assign rd_f = ir[IR_RD_HI:IR_RD_LO];
  assign rs_f = ir[IR_RS_HI:IR_RS_LO];
  assign unused_bits = ^{ir[5:0], wait_count};

  assign in_wait = (state == ST_FW) || (state == ST_LW) || (state == ST_SW);

  mem_wait_timer #(.CNT_W(CNT_W), .LIMIT(WAIT_LIMIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (in_wait && !mem_ready),
    .count   (wait_count),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_F0:  if (run) state_next = ST_F1;
      ST_F1:  state_next = ST_F2;
      ST_F2:  state_next = ST_FW;
      ST_FW:  if (mem_ready) state_next = ST_DEC;
              else if (expired) state_next = ST_FLT;
      ST_DEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = ST_A0;
          OP_LD:   state_next = ST_L0;
          OP_ST:   state_next = ST_S0;
          OP_NOP:  state_next = ST_F0;
          OP_HALT: state_next = ST_HLT;
          default: state_next = ST_FLT;
        endcase
      end
      ST_A0:  state_next = ST_A1;
      ST_A1:  state_next = ST_A2;
      ST_A2:  state_next = ST_A3;
      ST_A3:  state_next = ST_A4;
      ST_A4:  state_next = ST_F0;
      ST_L0:  state_next = ST_L1;
      ST_L1:  state_next = ST_L2;
      ST_L2:  state_next = ST_LW;
      ST_LW:  if (mem_ready) state_next = ST_L3;
              else if (expired) state_next = ST_FLT;
      ST_L3:  state_next = ST_L4;
      ST_L4:  state_next = ST_F0;
      ST_S0:  state_next = ST_S1;
      ST_S1:  state_next = ST_S2;
      ST_S2:  state_next = ST_S3;
      ST_S3:  state_next = ST_S4;
      ST_S4:  state_next = ST_S5;
      ST_S5:  state_next = ST_SW;
      ST_SW:  if (mem_ready) state_next = ST_F0;
              else if (expired) state_next = ST_FLT;
      ST_HLT: state_next = ST_HLT;
      ST_FLT: state_next = ST_FLT;
      default: state_next = ST_FLT;
    endcase
  end

  // Control vector for a state. IR and MDR loads are held through the whole
  // wait state, so the final load lands on the edge where mem_ready is seen
  // and datain is valid.
  function automatic ctrl_t decode(input logic [STATE_W-1:0] st,
                                   input logic [3:0] opc,
                                   input logic [2:0] rd,
                                   input logic [2:0] rs);
    ctrl_t c;
    c = '0;
    case (st)
      ST_F0:  begin c.tpc = 1'b1; c.ldy = 1'b1; end
      ST_F1:  begin c.fnsel = FNSEL_PASS; c.lmar = 1'b1; c.t2 = 1'b1; c.ldx = 1'b1; end
      ST_F2:  begin c.fnsel = FNSEL_ADD; c.lpc = 1'b1; end
      ST_FW:  begin c.mem_rd = 1'b1; c.lir = 1'b1; end
      ST_A0:  begin c.pa = rd; c.rdr = 1'b1; end
      ST_A1:  begin c.tp = 1'b1; c.ldx = 1'b1; end
      ST_A2:  begin c.pa = rs; c.rdr = 1'b1; end
      ST_A3:  begin c.tp = 1'b1; c.ldy = 1'b1; end
      ST_A4:  begin c.fnsel = fnsel_for_op(opc); c.wpa = rd; c.wrr = 1'b1; end
      ST_L0:  begin c.pa = rs; c.rdr = 1'b1; end
      ST_L1:  begin c.tp = 1'b1; c.ldy = 1'b1; end
      ST_L2:  begin c.fnsel = FNSEL_PASS; c.lmar = 1'b1; end
      ST_LW:  begin c.mem_rd = 1'b1; c.rmarx = 1'b1; c.lmdr = 1'b1; end
      ST_L3:  begin c.tmdr2x = 1'b1; c.ldy = 1'b1; end
      ST_L4:  begin c.fnsel = FNSEL_PASS; c.wpa = rd; c.wrr = 1'b1; end
      ST_S0:  begin c.pa = rs; c.rdr = 1'b1; end
      ST_S1:  begin c.tp = 1'b1; c.ldy = 1'b1; end
      ST_S2:  begin c.fnsel = FNSEL_PASS; c.lmar = 1'b1; end
      ST_S3:  begin c.pa = rd; c.rdr = 1'b1; end
      ST_S4:  begin c.tp = 1'b1; c.ldy = 1'b1; end
      ST_S5:  begin c.fnsel = FNSEL_PASS; c.rmdri = 1'b1; c.lmdr = 1'b1; end
      ST_SW:  c.mem_wr = 1'b1;
      ST_HLT: c.halted = 1'b1;
      ST_FLT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they line up with the
  // state register in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_F0;
      ctrl_q <= '0;
    end else begin
      state  <= state_next;
      ctrl_q <= decode(state_next, op, rd_f, rs_f);
    end
  end

  assign lmar   = ctrl_q.lmar;
  assign lt     = ctrl_q.lt;
  assign lpc    = ctrl_q.lpc;
  assign lir    = ctrl_q.lir;
  assign lmdr   = ctrl_q.lmdr;
  assign ldx    = ctrl_q.ldx;
  assign ldy    = ctrl_q.ldy;
  assign tt     = ctrl_q.tt;
  assign tpc    = ctrl_q.tpc;
  assign tp     = ctrl_q.tp;
  assign t2     = ctrl_q.t2;
  assign tmdr2x = ctrl_q.tmdr2x;
  assign rmdri  = ctrl_q.rmdri;
  assign rmarx  = ctrl_q.rmarx;
  assign rdr    = ctrl_q.rdr;
  assign wrr    = ctrl_q.wrr;
  assign pa     = ctrl_q.pa;
  assign wpa    = ctrl_q.wpa;
  assign fnsel  = ctrl_q.fnsel;
  assign mem_rd = ctrl_q.mem_rd;
  assign mem_wr = ctrl_q.mem_wr;
  assign halted = ctrl_q.halted;
  assign fault  = ctrl_q.fault;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, which are compared
// against the DUT outputs cycle by cycle.
module tb_datapath_controller;

  localparam int WAIT_LIMIT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, mem_ready;
  logic [15:0] ir;
  logic lmar, lt, lpc, lir, lmdr, ldx, ldy, tt, tpc, tp, t2, tmdr2x;
  logic rmdri, rmarx, rdr, wrr, mem_rd, mem_wr, halted, fault;
  logic [2:0] pa, wpa, fnsel;

  datapath_controller #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .ir(ir), .mem_ready(mem_ready),
    .lmar(lmar), .lt(lt), .lpc(lpc), .lir(lir), .lmdr(lmdr), .ldx(ldx), .ldy(ldy),
    .tt(tt), .tpc(tpc), .tp(tp), .t2(t2), .tmdr2x(tmdr2x),
    .rmdri(rmdri), .rmarx(rmarx), .rdr(rdr), .wrr(wrr),
    .pa(pa), .wpa(wpa), .fnsel(fnsel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .fault(fault)
  );

  typedef logic [28:0] vec_t;
  vec_t obs;
  assign obs = {lmar, lt, lpc, lir, lmdr, ldx, ldy, tt, tpc, tp, t2, tmdr2x,
                rmdri, rmarx, rdr, wrr, pa, wpa, fnsel, mem_rd, mem_wr, halted, fault};

  localparam vec_t V_LMAR   = vec_t'(1) << 28;
  localparam vec_t V_LPC    = vec_t'(1) << 26;
  localparam vec_t V_LIR    = vec_t'(1) << 25;
  localparam vec_t V_LMDR   = vec_t'(1) << 24;
  localparam vec_t V_LDX    = vec_t'(1) << 23;
  localparam vec_t V_LDY    = vec_t'(1) << 22;
  localparam vec_t V_TPC    = vec_t'(1) << 20;
  localparam vec_t V_TP     = vec_t'(1) << 19;
  localparam vec_t V_T2     = vec_t'(1) << 18;
  localparam vec_t V_TMDR2X = vec_t'(1) << 17;
  localparam vec_t V_RMDRI  = vec_t'(1) << 16;
  localparam vec_t V_RMARX  = vec_t'(1) << 15;
  localparam vec_t V_RDR    = vec_t'(1) << 14;
  localparam vec_t V_WRR    = vec_t'(1) << 13;
  localparam vec_t V_MEMRD  = vec_t'(1) << 3;
  localparam vec_t V_MEMWR  = vec_t'(1) << 2;
  localparam vec_t V_HALTED = vec_t'(1) << 1;
  localparam vec_t V_FAULT  = vec_t'(1);

  function automatic vec_t v_pa(input int a);  return vec_t'(a & 7) << 10; endfunction
  function automatic vec_t v_wpa(input int a); return vec_t'(a & 7) << 7;  endfunction
  function automatic vec_t v_fn(input int f);  return vec_t'(f & 7) << 4;  endfunction

  typedef struct {
    vec_t        v;
    logic        rdy;
    logic [15:0] irv;
  } step_t;

  step_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void push(input vec_t v, input logic rdy, input logic [15:0] irv);
    step_t s;
    s.v = v; s.rdy = rdy; s.irv = irv;
    exp_q.push_back(s);
  endfunction

  // Memory answers in wait cycle 'lat' (1-based); beyond WAIT_LIMIT it never
  // answers and the block faults. Returns 1 on timeout.
  function automatic bit push_wait(input vec_t v, input int lat, input logic [15:0] irv);
    for (int i = 1; i <= WAIT_LIMIT; i++) begin
      push(v, i == lat, irv);
      if (i == lat) return 1'b0;
    end
    for (int i = 0; i < 3; i++) push(V_FAULT, 1'b1, irv);
    return 1'b1;
  endfunction

  // One instruction from its F0 cycle up to its last cycle. A fresh F0 is the
  // cycle right after reset, where outputs are still cleared.
  function automatic void model_instr(input bit fresh, input logic [15:0] irv,
                                      input int f_lat, input int d_lat);
    logic [3:0] op;
    int rd, rs;
    op = irv[15:12];
    rd = int'(irv[11:9]);
    rs = int'(irv[8:6]);
    push(fresh ? vec_t'(0) : (V_TPC | V_LDY), 1'b0, irv);
    push(V_LMAR | V_T2 | V_LDX, 1'b0, irv);
    push(v_fn(4) | V_LPC, 1'b0, irv);
    if (push_wait(V_MEMRD | V_LIR, f_lat, irv)) return;
    push(vec_t'(0), 1'b0, irv);
    if (op >= 1 && op <= 4) begin
      push(v_pa(rd) | V_RDR, 1'b0, irv);
      push(V_TP | V_LDX, 1'b0, irv);
      push(v_pa(rs) | V_RDR, 1'b0, irv);
      push(V_TP | V_LDY, 1'b0, irv);
      push(v_fn(int'(op) + 3) | v_wpa(rd) | V_WRR, 1'b0, irv);
    end else if (op == 5) begin
      push(v_pa(rs) | V_RDR, 1'b0, irv);
      push(V_TP | V_LDY, 1'b0, irv);
      push(V_LMAR, 1'b0, irv);
      if (push_wait(V_MEMRD | V_RMARX | V_LMDR, d_lat, irv)) return;
      push(V_TMDR2X | V_LDY, 1'b0, irv);
      push(v_wpa(rd) | V_WRR, 1'b0, irv);
    end else if (op == 6) begin
      push(v_pa(rs) | V_RDR, 1'b0, irv);
      push(V_TP | V_LDY, 1'b0, irv);
      push(V_LMAR, 1'b0, irv);
      push(v_pa(rd) | V_RDR, 1'b0, irv);
      push(V_TP | V_LDY, 1'b0, irv);
      push(V_RMDRI | V_LMDR, 1'b0, irv);
      if (push_wait(V_MEMWR, d_lat, irv)) return;
    end else if (op == 7) begin
      for (int i = 0; i < 4; i++) push(V_HALTED, i[0], irv);
    end else if (op != 0) begin
      for (int i = 0; i < 4; i++) push(V_FAULT, i[0], irv);
    end
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  // Per-cycle structural rules.
  always @(negedge clk) begin
    n_tests++;
    if ($countones({tt, tpc, tp, t2, tmdr2x}) > 1 || (rmdri & rmarx) === 1'b1) begin
      n_fail++;
      $display("FAIL bus_rule t=%0t drivers=%b rmdri/rmarx=%b%b",
               $time, {tt, tpc, tp, t2, tmdr2x}, rmdri, rmarx);
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = 16'h1280;
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== vec_t'(0)) begin
      n_fail++; $display("FAIL reset_outputs got %h expected 0", obs);
    end
    rst = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (obs !== ((i == 0) ? vec_t'(0) : (V_TPC | V_LDY))) begin
        n_fail++; $display("FAIL idle_run0 cycle %0d got %h", i, obs);
      end
      @(negedge clk);
    end
    run = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== (V_LMAR | V_T2 | V_LDX)) begin
      n_fail++; $display("FAIL run_leaves_f0 got %h expected %h", obs, V_LMAR | V_T2 | V_LDX);
    end
  endtask

  task automatic test_alu();
    logic [15:0] irs [4];
    int lats [4];
    irs[0] = 16'h1280; lats[0] = 3;
    irs[1] = {4'd2, 3'($urandom), 3'($urandom), 6'($urandom)}; lats[1] = WAIT_LIMIT;
    irs[2] = {4'd3, 3'($urandom), 3'($urandom), 6'($urandom)}; lats[2] = 1;
    irs[3] = {4'd4, 3'($urandom), 3'($urandom), 6'($urandom)}; lats[3] = int'($urandom_range(1, 15));
    for (int k = 0; k < 4; k++) begin
      reset_dut();
      run = 1'b1;
      model_instr(1'b1, irs[k], lats[k], 0);
      push(V_TPC | V_LDY, 1'b0, irs[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs !== exp_q[i].v) begin
          n_fail++; $display("FAIL alu[%0d] ir=%h step %0d got %h expected %h", k, irs[k], i, obs, exp_q[i].v);
        end
        mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_ld_st();
    logic [15:0] irs [4];
    int fl [4], dl [4];
    irs[0] = 16'h5A40; fl[0] = 1; dl[0] = 1;
    irs[1] = 16'h6640; fl[1] = 2; dl[1] = int'($urandom_range(2, 15));
    irs[2] = {4'd5, 3'($urandom), 3'($urandom), 6'd0}; fl[2] = 1; dl[2] = WAIT_LIMIT;
    irs[3] = {4'd6, 3'($urandom), 3'($urandom), 6'd0}; fl[3] = 1; dl[3] = WAIT_LIMIT + 1;
    for (int k = 0; k < 4; k++) begin
      reset_dut();
      run = 1'b1;
      model_instr(1'b1, irs[k], fl[k], dl[k]);
      if (dl[k] <= WAIT_LIMIT) push(V_TPC | V_LDY, 1'b0, irs[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs !== exp_q[i].v) begin
          n_fail++; $display("FAIL ldst[%0d] ir=%h step %0d got %h expected %h", k, irs[k], i, obs, exp_q[i].v);
        end
        mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    run = 1'b1;
    model_instr(1'b1, 16'h1280, 1000, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs !== exp_q[i].v) begin
        n_fail++; $display("FAIL fetch_timeout step %0d got %h expected %h", i, obs, exp_q[i].v);
      end
      mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
      @(negedge clk);
    end
  endtask

  task automatic test_edge();
    logic [15:0] irs [4];
    irs[0] = 16'h7000;
    irs[1] = 16'h9000;
    irs[2] = {4'($urandom_range(8, 15)), 12'($urandom)};
    irs[3] = {4'd0, 12'($urandom)};
    for (int k = 0; k < 4; k++) begin
      reset_dut();
      run = 1'b1;
      model_instr(1'b1, irs[k], 2, 0);
      if (k == 3) push(V_TPC | V_LDY, 1'b0, irs[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (obs !== exp_q[i].v) begin
          n_fail++; $display("FAIL edge[%0d] ir=%h step %0d got %h expected %h", k, irs[k], i, obs, exp_q[i].v);
        end
        mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_in_lw();
    reset_dut();
    run = 1'b1;
    model_instr(1'b1, 16'h5A40, 1, 1000);
    // steps 0..9: F0 F1 F2 FW DEC L0 L1 L2 LW LW
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (obs !== exp_q[i].v) begin
        n_fail++; $display("FAIL lw_reset_pre step %0d got %h expected %h", i, obs, exp_q[i].v);
      end
      mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
      @(negedge clk);
    end
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== vec_t'(0)) begin
      n_fail++; $display("FAIL lw_reset_clears got %h expected 0", obs);
    end
    rst = 1'b1; mem_ready = 1'b0;
    exp_q.delete();
    model_instr(1'b1, 16'h1280, 1, 0);
    push(V_TPC | V_LDY, 1'b0, 16'h1280);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs !== exp_q[i].v) begin
        n_fail++; $display("FAIL lw_reset_post step %0d got %h expected %h", i, obs, exp_q[i].v);
      end
      mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] irv;
    reset_dut();
    run = 1'b1;
    irv = 16'h0;
    for (int n = 0; n < 25; n++) begin
      irv = {4'($urandom_range(0, 6)), 3'($urandom), 3'($urandom), 6'($urandom)};
      model_instr(n == 0, irv, int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
    end
    push(V_TPC | V_LDY, 1'b0, irv);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (obs !== exp_q[i].v) begin
        n_fail++; $display("FAIL b2b step %0d ir=%h got %h expected %h", i, exp_q[i].irv, obs, exp_q[i].v);
      end
      mem_ready = exp_q[i].rdy; ir = exp_q[i].irv;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 16'h0;
    test_reset();
    test_alu();
    test_ld_st();
    test_timeout();
    test_edge();
    test_reset_in_lw();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
